// File: rtl/r_resp_tracker.sv
// In-order OBI response tracker: queues accepted request IDs and pairs each
// controller completion with the oldest outstanding ID as a registered response beat.
module r_resp_tracker #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_accept_i,
    input  logic [ID_WIDTH-1:0]        req_id_i,
    output logic                       can_accept_o,
    input  logic                       ctrl_valid_i,
    input  logic [DATA_WIDTH-1:0]      ctrl_rdata_i,
    input  logic                       ctrl_err_i,
    output logic                       rvalid_o,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic                       err_o,
    output logic [ID_WIDTH-1:0]        rid_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       overflow_o,
    output logic                       orphan_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [ID_WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [ID_WIDTH-1:0]   r_rid;
    logic                  r_overflow;
    logic                  r_orphan;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full/empty come from the registered count only; no same-cycle bypass.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = req_accept_i & ~w_full;
    assign w_pop   = ctrl_valid_i & ~w_empty;

    assign can_accept_o  = ~w_full;
    assign outstanding_o = r_count;
    assign rvalid_o      = r_rvalid;
    assign rdata_o       = r_rdata;
    assign err_o         = r_err;
    assign rid_o         = r_rid;
    assign overflow_o    = r_overflow;
    assign orphan_o      = r_orphan;

    // ID storage; entries are only read after being written, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= req_id_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle response beat; an orphan completion is reported as an error with ID 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_rid    <= '0;
        end else if (ctrl_valid_i) begin
            r_rvalid <= 1'b1;
            r_rdata  <= ctrl_rdata_i;
            r_err    <= w_empty ? 1'b1 : ctrl_err_i;
            r_rid    <= w_empty ? '0 : r_mem[r_rptr];
        end else begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_rid    <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_orphan   <= 1'b0;
        end else begin
            if (req_accept_i && w_full) begin
                r_overflow <= 1'b1;
            end
            if (ctrl_valid_i && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_r_resp_tracker.sv
// Bench for r_resp_tracker: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_r_resp_tracker;

    localparam int unsigned DW    = 64;
    localparam int unsigned IDW   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH+1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_accept_i = 1'b0;
    logic [IDW-1:0] req_id_i = '0;
    logic           can_accept_o;
    logic           ctrl_valid_i = 1'b0;
    logic [DW-1:0]  ctrl_rdata_i = '0;
    logic           ctrl_err_i = 1'b0;
    logic           rvalid_o;
    logic [DW-1:0]  rdata_o;
    logic           err_o;
    logic [IDW-1:0] rid_o;
    logic [CW-1:0]  outstanding_o;
    logic           overflow_o;
    logic           orphan_o;

    always #5 clk = ~clk;

    r_resp_tracker #(.DATA_WIDTH(DW), .ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_accept_i  (req_accept_i),
        .req_id_i      (req_id_i),
        .can_accept_o  (can_accept_o),
        .ctrl_valid_i  (ctrl_valid_i),
        .ctrl_rdata_i  (ctrl_rdata_i),
        .ctrl_err_i    (ctrl_err_i),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .rid_o         (rid_o),
        .outstanding_o (outstanding_o),
        .overflow_o    (overflow_o),
        .orphan_o      (orphan_o)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: a plain queue of outstanding IDs plus expected outputs.
    logic [IDW-1:0] q[$];
    logic           exp_rvalid = 1'b0;
    logic [DW-1:0]  exp_rdata  = '0;
    logic           exp_err    = 1'b0;
    logic [IDW-1:0] exp_rid    = '0;
    logic           exp_ovf    = 1'b0;
    logic           exp_orph   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_rvalid = 1'b0;
        exp_rdata  = '0;
        exp_err    = 1'b0;
        exp_rid    = '0;
        exp_ovf    = 1'b0;
        exp_orph   = 1'b0;
    endtask

    task automatic model_step(input logic acc, input logic [IDW-1:0] id, input logic cv,
                              input logic [DW-1:0] rd, input logic e);
        bit was_full;
        was_full = (q.size() == int'(DEPTH));
        if (cv) begin
            exp_rvalid = 1'b1;
            exp_rdata  = rd;
            if (q.size() == 0) begin
                exp_err  = 1'b1;
                exp_rid  = '0;
                exp_orph = 1'b1;
            end else begin
                exp_rid = q.pop_front();
                exp_err = e;
            end
        end else begin
            exp_rvalid = 1'b0;
            exp_rdata  = '0;
            exp_err    = 1'b0;
            exp_rid    = '0;
        end
        if (acc) begin
            if (was_full) exp_ovf = 1'b1;
            else          q.push_back(id);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return just after it.
    task automatic step(input logic acc, input logic [IDW-1:0] id, input logic cv,
                        input logic [DW-1:0] rd, input logic e);
        req_accept_i = acc;
        req_id_i     = id;
        ctrl_valid_i = cv;
        ctrl_rdata_i = rd;
        ctrl_err_i   = e;
        @(posedge clk);
        model_step(acc, id, cv, rd, e);
        #1;
        req_accept_i = 1'b0;
        req_id_i     = '0;
        ctrl_valid_i = 1'b0;
        ctrl_rdata_i = '0;
        ctrl_err_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        req_accept_i = 1'b0;
        ctrl_valid_i = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_can_accept", 64'(can_accept_o), 64'd1);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        rst_n = 1'b1;
    endtask

    // Compare process: every output against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("rvalid", 64'(rvalid_o), 64'(exp_rvalid));
                chk("rdata", 64'(rdata_o), 64'(exp_rdata));
                chk("err", 64'(err_o), 64'(exp_err));
                chk("rid", 64'(rid_o), 64'(exp_rid));
                chk("outstanding", 64'(outstanding_o), 64'(q.size()));
                chk("can_accept", 64'(can_accept_o), 64'(q.size() < int'(DEPTH)));
                chk("overflow", 64'(overflow_o), 64'(exp_ovf));
                chk("orphan", 64'(orphan_o), 64'(exp_orph));
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        do_reset(2);

        // In-order pairing
        step(1'b1, 4'd3, 1'b0, '0, 1'b0);
        step(1'b1, 4'd7, 1'b0, '0, 1'b0);
        step(1'b1, 4'd1, 1'b0, '0, 1'b0);
        chk("pair_outstanding3", 64'(outstanding_o), 64'd3);
        idle(1);
        step(1'b0, '0, 1'b1, 64'hA, 1'b0);
        chk("pair0_rid", 64'(rid_o), 64'd3);
        chk("pair0_rdata", rdata_o, 64'hA);
        step(1'b0, '0, 1'b1, 64'hB, 1'b1);
        chk("pair1_rid", 64'(rid_o), 64'd7);
        chk("pair1_err", 64'(err_o), 64'd1);
        step(1'b0, '0, 1'b1, 64'hC, 1'b0);
        chk("pair2_rid", 64'(rid_o), 64'd1);
        chk("pair2_err", 64'(err_o), 64'd0);
        idle(1);
        chk("pair_rvalid_pulse", 64'(rvalid_o), 64'd0);
        chk("pair_outstanding0", 64'(outstanding_o), 64'd0);

        // Fill to DEPTH, then overflow with ID 9
        for (int i = 0; i < 4; i++) step(1'b1, IDW'(i), 1'b0, '0, 1'b0);
        chk("full_can_accept", 64'(can_accept_o), 64'd0);
        chk("full_outstanding", 64'(outstanding_o), 64'd4);
        step(1'b1, 4'd9, 1'b0, '0, 1'b0);
        chk("full_overflow", 64'(overflow_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 64'(100 + i), 1'b0);
            chk("full_drain_rid", 64'(rid_o), 64'(i));
        end
        idle(1);
        do_reset(1);

        // Simultaneous push and pop
        step(1'b1, 4'd5, 1'b0, '0, 1'b0);
        step(1'b1, 4'd6, 1'b1, 64'h55, 1'b0);
        chk("simul_rid", 64'(rid_o), 64'd5);
        chk("simul_outstanding", 64'(outstanding_o), 64'd1);
        step(1'b0, '0, 1'b1, 64'h66, 1'b0);
        chk("simul_next_rid", 64'(rid_o), 64'd6);
        idle(1);

        // Push and completion together while empty
        step(1'b1, 4'd2, 1'b1, 64'h77, 1'b0);
        chk("empty_err", 64'(err_o), 64'd1);
        chk("empty_rid", 64'(rid_o), 64'd0);
        chk("empty_orphan", 64'(orphan_o), 64'd1);
        chk("empty_outstanding", 64'(outstanding_o), 64'd1);
        step(1'b0, '0, 1'b1, 64'h88, 1'b1);
        chk("empty_next_rid", 64'(rid_o), 64'd2);
        chk("empty_next_err", 64'(err_o), 64'd1);
        idle(1);

        // Reset with traffic outstanding
        step(1'b1, 4'd4, 1'b0, '0, 1'b0);
        step(1'b1, 4'd8, 1'b0, '0, 1'b0);
        do_reset(2);
        chk("rst_orphan_clear", 64'(orphan_o), 64'd0);
        step(1'b0, '0, 1'b1, 64'h99, 1'b0);
        chk("rst_then_orphan", 64'(orphan_o), 64'd1);
        idle(1);
        do_reset(1);

        // Wrap-around of the ID pointers
        for (int i = 0; i < 10; i++) begin
            step(1'b1, IDW'(i), 1'b0, '0, 1'b0);
            step(1'b0, '0, 1'b1, 64'(i * 3), 1'b0);
            chk("wrap_rid", 64'(rid_o), 64'(i));
        end
        chk("wrap_no_overflow", 64'(overflow_o), 64'd0);
        chk("wrap_no_orphan", 64'(orphan_o), 64'd0);

        // Randomized traffic with a mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset(1);
            step($urandom_range(0, 99) < 55, IDW'($urandom), $urandom_range(0, 99) < 45,
                 {$urandom, $urandom}, 1'($urandom));
        end
        idle(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/r_resp_tracker.md
# r_resp_tracker

In-order response tracker that sits directly upstream of the OBI R-channel register stage. It records the ID of every accepted OBI request in a small FIFO, pairs each controller completion with the oldest outstanding ID, and presents a registered single-cycle response beat (valid, data, error, ID) to the R-channel stage. It also exports a grant-gating signal so the A-channel never accepts more requests than can be tracked.

## Interface

Parameters:
- DATA_WIDTH, 64, read data width; equals the R-channel stage's DATA_WIDTH
- ID_WIDTH, 4, request/response ID width
- DEPTH, 4, maximum outstanding requests; power of two, ≥2

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_accept_i  input  1  pulse: OBI request handshake completed (req & gnt) this cycle
- req_id_i  input  ID_WIDTH  aid of the accepted request; sampled when req_accept_i=1
- can_accept_o  output  1  1 when tracker not full; A-channel ANDs this into gnt
- ctrl_valid_i  input  1  pulse: controller completes the oldest outstanding request
- ctrl_rdata_i  input  DATA_WIDTH  completion read data
- ctrl_err_i  input  1  completion error
- rvalid_o  output  1  response beat valid (to R-channel rvalid_in)
- rdata_o  output  DATA_WIDTH  response data (to rdata_in)
- err_o  output  1  response error (to err_in)
- rid_o  output  ID_WIDTH  response ID (to rid_in)
- outstanding_o  output  $clog2(DEPTH+1)  current occupancy
- overflow_o  output  1  sticky: push attempted while full
- orphan_o  output  1  sticky: completion received with no outstanding request

## Operation

- ID FIFO: DEPTH entries, write/read pointers of $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy counter of $clog2(DEPTH+1) bits.
- Push: req_accept_i=1 and count<DEPTH → store req_id_i at wptr, wptr+1.
- Pop: ctrl_valid_i=1 and count>0 → read ID at rptr, rptr+1.
- Push and pop in same cycle: both performed, count unchanged. Pop sees only entries pushed in earlier cycles (no same-cycle bypass).
- can_accept_o = (count < DEPTH), combinational from registered count; does not anticipate a same-cycle pop.
- Push while full: request ID dropped, pointers/count unchanged, overflow_o set.
- Completion with count=0: beat still emitted with rdata_o=ctrl_rdata_i, err_o=1, rid_o=0; orphan_o set; no pointer change.
- Normal completion: beat carries ctrl_rdata_i, ctrl_err_i, popped ID.
- No ctrl_valid_i: rvalid_o=0, rdata_o=0, err_o=0, rid_o=0 (outputs cleared, matching R-channel stage convention).
- No backpressure: R path has no ready; one beat per cycle maximum; controller completes at most one request per cycle.
- overflow_o / orphan_o cleared only by reset.

## Timing

- Reset (async, any time incl. mid-operation): pointers=0, count=0, outstanding_o=0, can_accept_o=1, rvalid_o=0, rdata_o=0, err_o=0, rid_o=0, overflow_o=0, orphan_o=0. All tracked IDs discarded.
- Response outputs registered: ctrl_valid_i at edge N → rvalid_o/rdata_o/err_o/rid_o valid for cycle N+1 only (one-cycle pulse). R-channel stage adds one more → OBI rvalid at N+2.
- outstanding_o, can_accept_o update the cycle after the push/pop edge.
- Back-to-back completions on consecutive cycles produce back-to-back beats with consecutive IDs.
- Sticky flags assert the cycle after the offending event.

## Test plan

- Reset: hold rst_n=0 mid-traffic with 2 outstanding → all outputs zero, can_accept_o=1, outstanding_o=0; subsequent completion flags orphan.
- In-order pairing: accept IDs 3,7,1 on cycles 1-3; completions with rdata 0xA,0xB,0xC, err 0,1,0 on cycles 5-7 → beats cycles 6-8: (0xA,0,3),(0xB,1,7),(0xC,0,1); outstanding_o back to 0.
- Full: DEPTH=4, accept IDs 0-3 → can_accept_o=0, outstanding_o=4; 5th req_accept_i with ID 9 → overflow_o=1, next completions return IDs 0,1,2,3 (9 never appears).
- Simultaneous push/pop: 1 outstanding (ID 5); same cycle accept ID 6 and complete → beat rid=5, outstanding_o stays 1; next completion → rid=6.
- Empty-same-cycle: count=0, accept ID 2 and ctrl_valid_i same cycle → beat err=1, rid=0, orphan_o=1, outstanding_o=1; following completion → rid=2, err=ctrl_err_i.
- Wrap-around: 10 accept/complete pairs with IDs 0..9 (mod 16) at count ≤2 → every beat rid matches accept order across pointer wrap; no flags set.
